// File: rtl/stack_program_loader.sv
// Program loader for the 8-bit stack machine: unpacks a byte stream into a 32 x 12-bit store and releases run once the checksum verifies.
// Optional reload from RUN (byte 8'hFF) is enabled by defining LOADER_RELOAD_EN.
module stack_program_loader #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned OP_W  = 4,
    parameter int unsigned VAL_W = 8
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [8:1]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:1]  fetch_addr,
    output logic [1:12] fetch_inst,
    output logic        run,
    output logic        error,
    output logic [6:1]  loaded_count
);

    localparam int unsigned AW = 5;
    localparam int unsigned IW = OP_W + VAL_W;
    localparam int unsigned CW = 6;

    typedef enum logic [2:0] {
        S_HDR,
        S_OP,
        S_VAL,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t          state;
    logic [AW-1:0]   index;
    logic [7:0]      sum;
    logic [OP_W-1:0] op_q;
    logic [IW-1:0]   store [DEPTH];
    logic            accept;

`ifdef LOADER_RELOAD_EN
    assign in_ready = (state != S_ERR);
`else
    assign in_ready = (state != S_RUN) && (state != S_ERR);
`endif

    assign accept     = in_valid && in_ready;
    assign fetch_inst = store[fetch_addr];

    // Stream parser: header, N {op, value} pairs, checksum byte.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state        <= S_HDR;
            run          <= 1'b0;
            error        <= 1'b0;
            loaded_count <= '0;
            index        <= '0;
            sum          <= '0;
            op_q         <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                store[AW'(i)] <= '0;
            end
        end else if (accept) begin
            case (state)
                S_HDR: begin
                    if (in_data == 8'd0 || in_data > 8'(DEPTH)) begin
                        state <= S_ERR;
                        error <= 1'b1;
                    end else begin
                        loaded_count <= CW'(in_data);
                        index        <= '0;
                        sum          <= in_data;
                        state        <= S_OP;
                    end
                end
                S_OP: begin
                    if (in_data[8:5] != 4'd0) begin
                        state <= S_ERR;
                        error <= 1'b1;
                    end else begin
                        op_q  <= in_data[4:1];
                        sum   <= 8'(sum + in_data);
                        state <= S_VAL;
                    end
                end
                S_VAL: begin
                    store[index] <= {op_q, in_data};
                    sum          <= 8'(sum + in_data);
                    if (CW'(index) == CW'(loaded_count - CW'(1))) begin
                        state <= S_CSUM;
                    end else begin
                        index <= AW'(index + AW'(1));
                        state <= S_OP;
                    end
                end
                S_CSUM: begin
                    if (8'(sum + in_data) == 8'd0) begin
                        run   <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        error <= 1'b1;
                        state <= S_ERR;
                    end
                end
                S_RUN: begin
`ifdef LOADER_RELOAD_EN
                    // 8'hFF drops the machine back into reset for a fresh load; other bytes are discarded.
                    if (in_data == 8'hFF) begin
                        run   <= 1'b0;
                        error <= 1'b0;
                        state <= S_HDR;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_program_loader.sv
// Self-checking bench for stack_program_loader: vector table, hand-written corner sequences, randomized loads vs a stream-level model.
module tb_stack_program_loader;

`ifdef LOADER_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    logic        clk;
    logic        rstN;
    logic [8:1]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [5:1]  fetch_addr;
    logic [1:12] fetch_inst;
    logic        run;
    logic        error;
    logic [6:1]  loaded_count;

    stack_program_loader dut (
        .clk          (clk),
        .rstN         (rstN),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fetch_addr   (fetch_addr),
        .fetch_inst   (fetch_inst),
        .run          (run),
        .error        (error),
        .loaded_count (loaded_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [0:7][7:0] b;
        int              len;
        logic            exp_run;
        logic            exp_err;
        logic [5:0]      exp_cnt;
        logic [11:0]     exp_f0;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [11:0] m_store [32];
    bit          m_ok;
    bit          m_err;
    logic [5:0]  m_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < 32; a++) m_store[a] = 12'h000;
        m_cnt = 6'd0;
        m_ok  = 1'b0;
        m_err = 1'b0;
    endtask

    // Stream-level reference: decode the whole byte sequence from the format rules.
    task automatic model_apply(input logic [7:0] s[$]);
        int         n;
        logic [7:0] total;
        m_ok  = 1'b0;
        m_err = 1'b0;
        n = int'(s[0]);
        if (n == 0 || n > 32) begin
            m_err = 1'b1;
            return;
        end
        m_cnt = 6'(n);
        total = 8'd0;
        foreach (s[i]) total = 8'(total + s[i]);
        for (int k = 0; k < n; k++) begin
            if (s[1 + 2*k][7:4] != 4'd0) begin
                m_err = 1'b1;
                return;
            end
            m_store[k] = {s[1 + 2*k][3:0], s[2 + 2*k]};
        end
        if (total == 8'd0) m_ok = 1'b1;
        else m_err = 1'b1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        rstN     = 1'b0;
        #7;
        rstN = 1'b1;
        @(negedge clk);
        model_clear();
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] s[$], input bit stall);
        foreach (s[i]) begin
            if (stall) begin
                while ($urandom_range(0, 2) == 0) idle();
            end
            send(s[i]);
        end
    endtask

    task automatic check_store(input string tag);
        for (int a = 0; a < 32; a++) begin
            fetch_addr = 5'(a);
            #1;
            check($sformatf("%s fetch[%0d]", tag, a), 32'(fetch_inst), 32'(m_store[a]));
        end
    endtask

    task automatic check_fetch(input string nm, input int a, input logic [11:0] exp);
        fetch_addr = 5'(a);
        #1;
        check(nm, 32'(fetch_inst), 32'(exp));
    endtask

    vec_t        vecs [6];
    logic [7:0]  good [$];
    logic [7:0]  q [$];
    logic [7:0]  sum;
    logic [7:0]  opb;
    logic        exp_rdy;
    int          n;

    initial begin
        vecs[0] = '{b: {8'h02, 8'h00, 8'h05, 8'h06, 8'h00, 8'hF3, 8'h00, 8'h00}, len: 6,
                    exp_run: 1'b1, exp_err: 1'b0, exp_cnt: 6'd2, exp_f0: 12'h005};
        vecs[1] = '{b: {8'h02, 8'h00, 8'h05, 8'h06, 8'h00, 8'hF4, 8'h00, 8'h00}, len: 6,
                    exp_run: 1'b0, exp_err: 1'b1, exp_cnt: 6'd2, exp_f0: 12'h000};
        vecs[2] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, len: 1,
                    exp_run: 1'b0, exp_err: 1'b1, exp_cnt: 6'd0, exp_f0: 12'h000};
        vecs[3] = '{b: {8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, len: 1,
                    exp_run: 1'b0, exp_err: 1'b1, exp_cnt: 6'd0, exp_f0: 12'h000};
        vecs[4] = '{b: {8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, len: 2,
                    exp_run: 1'b0, exp_err: 1'b1, exp_cnt: 6'd1, exp_f0: 12'h000};
        vecs[5] = '{b: {8'h01, 8'h0F, 8'hAA, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00}, len: 4,
                    exp_run: 1'b1, exp_err: 1'b0, exp_cnt: 6'd1, exp_f0: 12'hFAA};
        good = '{8'h02, 8'h00, 8'h05, 8'h06, 8'h00, 8'hF3};

        rstN       = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        fetch_addr = 5'd0;

        // Reset state
        do_reset();
        check("reset run", 32'(run), 32'(0));
        check("reset error", 32'(error), 32'(0));
        check("reset in_ready", 32'(in_ready), 32'(1));
        check("reset loaded_count", 32'(loaded_count), 32'(0));
        check_store("reset");

        // Vector table
        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].len; i++) send(vecs[v].b[i]);
            exp_rdy = vecs[v].exp_err ? 1'b0 : (vecs[v].exp_run ? RELOAD : 1'b1);
            check($sformatf("vec%0d run", v), 32'(run), 32'(vecs[v].exp_run));
            check($sformatf("vec%0d error", v), 32'(error), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d in_ready", v), 32'(in_ready), 32'(exp_rdy));
            check($sformatf("vec%0d loaded_count", v), 32'(loaded_count), 32'(vecs[v].exp_cnt));
            if (vecs[v].exp_run) check_fetch($sformatf("vec%0d fetch0", v), 0, vecs[v].exp_f0);
            send(8'h00);
            send(8'h00);
            check($sformatf("vec%0d run after extra", v), 32'(run), 32'(vecs[v].exp_run));
            check($sformatf("vec%0d error after extra", v), 32'(error), 32'(vecs[v].exp_err));
        end

        // run rises only on the checksum-accepting edge
        do_reset();
        for (int i = 0; i < 5; i++) send(good[i]);
        in_data  = 8'hF3;
        in_valid = 1'b1;
        #1;
        check("run before csum edge", 32'(run), 32'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("run after csum edge", 32'(run), 32'(1));
        check_fetch("good fetch1", 1, 12'h600);
        check_fetch("good fetch2", 2, 12'h000);

        // Read of the address being written returns the old word until the edge
        do_reset();
        send(8'h01);
        send(8'h03);
        fetch_addr = 5'd0;
        in_data    = 8'h0A;
        in_valid   = 1'b1;
        #1;
        check("fetch before write edge", 32'(fetch_inst), 32'(12'h000));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("fetch after write edge", 32'(fetch_inst), 32'(12'h30A));
        send(8'hF2);
        check("single load run", 32'(run), 32'(1));

        // Randomized loads with stalls; iteration 0 is full depth, 3 bad checksum, 4 bad op
        for (int it = 0; it < 8; it++) begin
            do_reset();
            n = (it == 0) ? 32 : int'($urandom_range(1, 32));
            q = {};
            q.push_back(8'(n));
            sum = 8'(n);
            for (int k = 0; k < n; k++) begin
                opb = 8'($urandom_range(0, 15));
                if (it == 4 && k == n - 1) opb = opb | 8'h30;
                q.push_back(opb);
                sum = 8'(sum + opb);
                q.push_back(8'($urandom));
                sum = 8'(sum + q[q.size() - 1]);
            end
            q.push_back((it == 3) ? 8'(8'd1 - sum) : 8'(8'd0 - sum));
            model_apply(q);
            send_q(q, 1'b1);
            exp_rdy = m_err ? 1'b0 : (m_ok ? RELOAD : 1'b1);
            check($sformatf("rand%0d run", it), 32'(run), 32'(m_ok));
            check($sformatf("rand%0d error", it), 32'(error), 32'(m_err));
            check($sformatf("rand%0d in_ready", it), 32'(in_ready), 32'(exp_rdy));
            check($sformatf("rand%0d loaded_count", it), 32'(loaded_count), 32'(m_cnt));
            if (m_ok) check_store($sformatf("rand%0d", it));
        end

        // Reset mid-load clears the store immediately
        do_reset();
        send(8'h02);
        send(8'h00);
        send(8'h05);
        check_fetch("midload fetch0 written", 0, 12'h005);
        rstN = 1'b0;
        #1;
        check("midload reset run", 32'(run), 32'(0));
        check("midload reset loaded_count", 32'(loaded_count), 32'(0));
        check("midload reset fetch0", 32'(fetch_inst), 32'(12'h000));
        rstN = 1'b1;
        @(negedge clk);
        model_clear();
        check("midload in_ready", 32'(in_ready), 32'(1));
        check_store("midload");

        // run drops asynchronously on reset
        do_reset();
        send_q(good, 1'b0);
        check("async pre run", 32'(run), 32'(1));
        rstN = 1'b0;
        #1;
        check("async run drop", 32'(run), 32'(0));
        check("async error", 32'(error), 32'(0));
        rstN = 1'b1;
        @(negedge clk);

`ifdef LOADER_RELOAD_EN
        // Reload from RUN: other bytes discarded, FF returns to header, stale entries kept
        do_reset();
        send_q(good, 1'b0);
        send(8'h12);
        check("reload run survives other byte", 32'(run), 32'(1));
        send(8'hFF);
        check("reload run drop", 32'(run), 32'(0));
        check("reload in_ready", 32'(in_ready), 32'(1));
        send(8'h01);
        send(8'h03);
        send(8'h0A);
        send(8'hF2);
        check("reload run", 32'(run), 32'(1));
        check("reload loaded_count", 32'(loaded_count), 32'(1));
        check_fetch("reload fetch0", 0, 12'h30A);
        check_fetch("reload fetch1 kept", 1, 12'h600);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_program_loader.md
Name: stack_program_loader

Overview:
- Upstream stage of the 8-bit stack machine: receives a program as a byte stream, packs it into a 32 x 12-bit instruction store, verifies a checksum, then releases the machine.
- Instruction format: bits [1:4] opcode, bits [5:12] operand, the layout the machine fetches.
- Machine fetches through an asynchronous read port.
- `run` drives the machine's active-low reset: the machine stays held until a program is loaded and verified.

Parameters:
- DEPTH, 32, number of instruction words; address width is fixed at 5 bits.
- OP_W, 4, opcode field width.
- VAL_W, 8, operand field width.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rstN  input  1  asynchronous, active-low reset.
- in_data  input  [8:1]  program byte stream.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  loader accepts a byte; transfer occurs when in_valid && in_ready at a rising clk edge.
- fetch_addr  input  [5:1]  instruction address from the machine's pc.
- fetch_inst  output  [1:12]  combinational read: {op, value} at fetch_addr.
- run  output  1  registered; 1 = program verified, machine may execute (connect to machine rstN).
- error  output  1  registered, sticky load failure.
- loaded_count  output  [6:1]  number of instructions accepted in the last header (0..32).

Behaviour:
- Reset (rstN=0, async):
  - state=HDR, run=0, error=0, loaded_count=0, index=0, checksum accumulator=0.
  - All 32 store entries cleared to 12'h000.
  - in_ready=1 after reset (decoded from state).
- Stream format: header N (1..32), then N pairs {op byte, value byte}, then one checksum byte.
- Checksum rule: header + all op bytes + all value bytes + checksum byte == 8'h00 (mod 256).
- State machine. A byte is consumed only on handshake; with in_valid=0 the state holds.
- HDR:
  - N==0 or N>32 -> ERR.
  - Otherwise loaded_count<=N, index<=0, sum<=N, -> OP.
- OP:
  - Byte[8:5] != 0 -> ERR.
  - Otherwise latch op=byte[4:1], sum+=byte, -> VAL.
- VAL:
  - store[index] <= {op, byte} (write on the accepting edge), sum+=byte.
  - If index==N-1 -> CSUM; else index+=1, -> OP.
- CSUM:
  - (sum+byte)==0 -> RUN, run<=1 on that same edge (run visible the cycle after checksum acceptance).
  - Otherwise -> ERR.
- RUN: in_ready=0, run=1; terminal until reset (see Optional Feature).
- ERR: in_ready=0, run=0, error=1; terminal until reset. Store contents partially written, unspecified for verification.
- in_ready is 1 in HDR, OP, VAL, CSUM; 0 in RUN, ERR.
- fetch_inst:
  - Pure combinational read; no read latency.
  - A fetch_addr equal to the address being written returns the old word until the edge.
  - Entries >= N keep their prior value (0 after reset).
- Arithmetic: sum is 8-bit wrap-around; index is 5-bit; loaded_count holds up to 32 in 6 bits.
- Reset asserted mid-load: immediate return to reset values; run drops asynchronously.

Optional Feature:
- Macro LOADER_RELOAD_EN.
- When defined:
  - In RUN, in_ready=1.
  - An accepted byte 8'hFF deasserts run on that edge, clears error, and returns to HDR.
  - Store is not cleared; a new load overwrites entries 0..N-1.
  - Any other byte in RUN is accepted and discarded.
- When undefined: RUN is terminal until rstN, with in_ready=0.

Test Plan:
- Reset: rstN low then high -> run=0, error=0, in_ready=1, loaded_count=0, fetch_inst=12'h000 for all 32 addresses.
- Valid 2-instruction load:
  - Stream 02, 00, 05, 06, 00, F3 (sum 02+00+05+06+00=0D, checksum F3).
  - Result: run=1 one cycle after F3 accepted, loaded_count=2, fetch_addr=0 -> 12'h005, fetch_addr=1 -> 12'h600, in_ready=0.
- Bad checksum: same stream with final byte F4 -> error=1, run=0, in_ready=0; further bytes ignored.
- Illegal fields:
  - Header 00 -> error=1.
  - Header 21 (33) -> error=1.
  - Header 01 then op byte 10 -> error=1 on that edge.
- Handshake stalls and full depth:
  - Header 20 (32 instructions) with in_valid toggled randomly; checksum computed per rule.
  - Result: all 32 words correct, index wraps cleanly at 31, run=1.
- Reset mid-load and reload:
  - rstN low after 3 bytes -> run=0, store cleared.
  - With LOADER_RELOAD_EN: byte FF in RUN -> run=0, state HDR, a second valid load succeeds.
